main_memory: RTL and testbench

MAIN_MEMORY -- requirements
Module: main_memory

---
 rtl/main_memory.sv | 69 ++++++
 tb/tb_main_memory.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/main_memory.sv
`default_nettype none
// ============================================================================
// Module      : main_memory
// Description : Word-organised RAM with a combinational read port, a packed
//               single-word write port and an asynchronous clear of all words.
// Revision    : 1.0 - initial release
// ============================================================================
module main_memory #(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_LSB    = 2
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic        ENABLE,
  input  logic [31:0] FETCH_ADDRESS,
  input  logic [64:0] EDIT_SERIAL,
  output logic [31:0] DATA
);

  localparam int c_idx_w = $clog2(DEPTH_WORDS);

  generate
    if ((DEPTH_WORDS < 4) || ((1 << c_idx_w) != DEPTH_WORDS)) begin : g_bad_depth
      $error("main_memory: DEPTH_WORDS must be a power of two and at least 4");
    end
    if ((ADDR_LSB < 0) || (ADDR_LSB + c_idx_w > 32)) begin : g_bad_lsb
      $error("main_memory: index field does not fit in a 32-bit address");
    end
  endgenerate

  logic [31:0]        r_mem [DEPTH_WORDS];

  logic               w_wr_req;
  logic [31:0]        w_wr_data;
  logic [31:0]        w_wr_addr;
  logic               w_wr_en;
  logic [c_idx_w-1:0] w_wr_idx;
  logic [c_idx_w-1:0] w_rd_idx;
  logic               w_unused;

  assign w_wr_req  = EDIT_SERIAL[64];
  assign w_wr_data = EDIT_SERIAL[63:32];
  assign w_wr_addr = EDIT_SERIAL[31:0];

  // Byte-offset bits and bits above the index are dropped, giving word
  // round-down and wrap-around aliasing for free.
  assign w_wr_idx = w_wr_addr[ADDR_LSB +: c_idx_w];
  assign w_rd_idx = FETCH_ADDRESS[ADDR_LSB +: c_idx_w];

  // The reset branch has priority, so a request on an edge with RESET low is lost.
  assign w_wr_en = ENABLE & w_wr_req;

  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < DEPTH_WORDS; i++) begin
        r_mem[i] <= 32'h0000_0000;
      end
    end else if (w_wr_en) begin
      r_mem[w_wr_idx] <= w_wr_data;
    end
  end

  // Plain array read: no bypass, so a same-word write is visible only after the edge.
  assign DATA = r_mem[w_rd_idx];

  assign w_unused = ^{FETCH_ADDRESS, w_wr_addr};

endmodule
`default_nettype wire

// File: tb/tb_main_memory.sv
`default_nettype none
// ============================================================================
// Module      : tb_main_memory
// Description : Directed and randomized checks of main_memory against a
//               word-array reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_main_memory;

  localparam int DEPTH = 256;
  localparam int LSB   = 2;

  logic        CLOCK = 1'b0;
  logic        RESET;
  logic        ENABLE;
  logic [31:0] FETCH_ADDRESS;
  logic [64:0] EDIT_SERIAL;
  logic [31:0] DATA;

  int checks = 0;
  int errors = 0;

  logic [31:0] model [DEPTH];

  main_memory #(.DEPTH_WORDS(DEPTH), .ADDR_LSB(LSB)) dut (
    .CLOCK        (CLOCK),
    .RESET        (RESET),
    .ENABLE       (ENABLE),
    .FETCH_ADDRESS(FETCH_ADDRESS),
    .EDIT_SERIAL  (EDIT_SERIAL),
    .DATA         (DATA)
  );

  always #5 CLOCK = ~CLOCK;

  function automatic int widx(logic [31:0] a);
    return int'((a / (32'd1 << LSB)) % DEPTH);
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
  endtask

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic read_chk(string tag, logic [31:0] a);
    FETCH_ADDRESS = a;
    #1;
    check(tag, DATA, model[widx(a)]);
  endtask

  // Present a write request at the falling edge, check the read port before
  // and after the rising edge, then drop the request.
  task automatic wr(string tag, logic [31:0] a, logic [31:0] d, logic en, logic req);
    @(negedge CLOCK);
    ENABLE      = en;
    EDIT_SERIAL = {req, d, a};
    #1;
    check({tag, "_pre"}, DATA, model[widx(FETCH_ADDRESS)]);
    @(posedge CLOCK);
    if (RESET && en && req) model[widx(a)] = d;
    #1;
    check({tag, "_post"}, DATA, model[widx(FETCH_ADDRESS)]);
    EDIT_SERIAL = '0;
    ENABLE      = 1'b0;
  endtask

  initial begin
    logic [31:0] a, d, f;
    logic        en, req;

    RESET         = 1'b1;
    ENABLE        = 1'b0;
    FETCH_ADDRESS = 32'h0;
    EDIT_SERIAL   = '0;
    model_clear();
    #2 RESET = 1'b0;
    repeat (2) @(posedge CLOCK);
    #1;
    check("rst_addr0", DATA, 32'h0);
    FETCH_ADDRESS = 32'h3FC; #1;
    check("rst_addr3fc", DATA, 32'h0);

    // A write presented across an edge with RESET low must be lost.
    FETCH_ADDRESS = 32'h44;
    wr("wr_in_rst", 32'h44, 32'h1357_9BDF, 1'b1, 1'b1);
    check("wr_in_rst_const", DATA, 32'h0);

    @(negedge CLOCK);
    RESET = 1'b1;

    // First write after reset release takes effect on the first edge.
    FETCH_ADDRESS = 32'h10;
    wr("first_wr", 32'h10, 32'hDEAD_BEEF, 1'b1, 1'b1);
    check("first_wr_const", DATA, 32'hDEAD_BEEF);

    // Reset asserted mid-cycle clears without a clock edge.
    #2 RESET = 1'b0;
    model_clear();
    #1;
    check("rst_async_clear", DATA, 32'h0);
    read_chk("rst_async_other", 32'h44);
    @(negedge CLOCK);
    RESET = 1'b1;

    // Basic write, read back at each byte offset of the word.
    wr("basic", 32'h8, 32'h1234_5678, 1'b1, 1'b1);
    for (int i = 8; i < 12; i++) begin
      FETCH_ADDRESS = 32'(i); #1;
      check("basic_offset", DATA, 32'h1234_5678);
    end

    // Gating: neither sub-case may alter 0x20.
    FETCH_ADDRESS = 32'h20;
    wr("gate_init", 32'h20, 32'hAAAA_AAAA, 1'b1, 1'b1);
    wr("gate_en0", 32'h20, 32'h5555_5555, 1'b0, 1'b1);
    check("gate_en0_const", DATA, 32'hAAAA_AAAA);
    wr("gate_req0", 32'h20, 32'h5555_5555, 1'b1, 1'b0);
    check("gate_req0_const", DATA, 32'hAAAA_AAAA);

    // Aliasing above the index range.
    FETCH_ADDRESS = 32'h0;
    wr("alias", 32'h400, 32'hCAFE_0001, 1'b1, 1'b1);
    check("alias_const", DATA, 32'hCAFE_0001);

    // Read-during-write: old value before the edge, new value after.
    FETCH_ADDRESS = 32'h30;
    wr("rdw_init", 32'h30, 32'h1, 1'b1, 1'b1);
    @(negedge CLOCK);
    ENABLE = 1'b1;
    EDIT_SERIAL = {1'b1, 32'h2, 32'h30};
    #1;
    check("rdw_before", DATA, 32'h1);
    @(posedge CLOCK);
    model[widx(32'h30)] = 32'h2;
    #1;
    check("rdw_after", DATA, 32'h2);
    EDIT_SERIAL = '0;
    ENABLE = 1'b0;

    // Back-to-back writes on consecutive edges.
    @(negedge CLOCK);
    ENABLE = 1'b1;
    EDIT_SERIAL = {1'b1, 32'h11, 32'h0};
    @(posedge CLOCK);
    model[0] = 32'h11;
    #1;
    EDIT_SERIAL = {1'b1, 32'h22, 32'h4};
    @(posedge CLOCK);
    model[1] = 32'h22;
    #1;
    EDIT_SERIAL = '0;
    ENABLE = 1'b0;
    FETCH_ADDRESS = 32'h0; #1;
    check("b2b_0", DATA, 32'h11);
    FETCH_ADDRESS = 32'h4; #1;
    check("b2b_4", DATA, 32'h22);

    // Randomized traffic against the model, with one mid-run reset.
    for (int i = 0; i < 400; i++) begin
      a   = ($urandom_range(0, 3) == 0) ? $urandom : ($urandom & 32'h0000_0FFF);
      d   = $urandom;
      en  = ($urandom_range(0, 3) != 0);
      req = ($urandom_range(0, 3) != 0);
      f   = ($urandom_range(0, 1) == 0) ? (a ^ 32'($urandom_range(0, 3))) : $urandom;
      FETCH_ADDRESS = f;
      wr("rand", a, d, en, req);
      if (i == 200) begin
        #2 RESET = 1'b0;
        model_clear();
        #1;
        check("rand_rst", DATA, 32'h0);
        @(negedge CLOCK);
        RESET = 1'b1;
      end
      if ((i % 16) == 0) read_chk("rand_sweep", $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
